// File: rtl/i_cache_assoc.sv
// 2-way set-associative instruction cache with true-LRU replacement and a handshake line-refill FSM.
// Optional hit/miss statistics counters are built when I_CACHE_ASSOC_STATS_EN is defined.
module i_cache_assoc #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_SETS   = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic                 pc_valid,
  input  logic                 flush,
  output logic [WORD_SIZE-1:0] inst,
  output logic                 inst_valid,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_ack,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int BO_W  = $clog2(LINE_WORDS);
  localparam int TAG_W = WORD_SIZE - IDX_W - BO_W;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [1:0]           valid_r [NUM_SETS];
  logic [NUM_SETS-1:0]  lru_r;
  logic [TAG_W-1:0]     tag_r   [2][NUM_SETS];
  logic [WORD_SIZE-1:0] data_r  [2][NUM_SETS][LINE_WORDS];

  logic [WORD_SIZE-BO_W-1:0] base_hi_r;
  logic [IDX_W-1:0]          idx_r;
  logic [TAG_W-1:0]          fill_tag_r;
  logic                      way_r;
  logic [BO_W-1:0]           cnt_r;

  logic [TAG_W-1:0] pc_tag_s;
  logic [IDX_W-1:0] pc_idx_s;
  logic [BO_W-1:0]  pc_off_s;
  logic [1:0]       way_hit_s;
  logic             lookup_s;
  logic             hit_s;
  logic             miss_s;
  logic             hit_way_s;
  logic             victim_s;
  logic             last_s;
  logic             fill_wr_s;

  assign pc_tag_s = pc[WORD_SIZE-1 -: TAG_W];
  assign pc_idx_s = pc[BO_W +: IDX_W];
  assign pc_off_s = pc[BO_W-1:0];

  // Tag compare, hit/miss classification, victim choice and fetch outputs.
  always_comb begin
    way_hit_s[0] = valid_r[pc_idx_s][0] && (tag_r[0][pc_idx_s] == pc_tag_s);
    way_hit_s[1] = valid_r[pc_idx_s][1] && (tag_r[1][pc_idx_s] == pc_tag_s);
    lookup_s     = (state_r == S_IDLE) && pc_valid && !flush;
    hit_s        = lookup_s && (way_hit_s != 2'b00);
    miss_s       = lookup_s && (way_hit_s == 2'b00);
    hit_way_s    = way_hit_s[1];
    last_s       = (cnt_r == BO_W'(LINE_WORDS - 1));
    fill_wr_s    = (state_r == S_REFILL) && mem_ack && !flush;
    // Prefer an invalid way; with both invalid fall back to way 0.
    case (valid_r[pc_idx_s])
      2'b00:   victim_s = 1'b0;
      2'b01:   victim_s = 1'b1;
      2'b10:   victim_s = 1'b0;
      default: victim_s = lru_r[pc_idx_s];
    endcase
    if (hit_s) begin
      inst = data_r[hit_way_s][pc_idx_s][pc_off_s];
    end else begin
      inst = '0;
    end
    inst_valid = hit_s;
    mem_req    = (state_r == S_REFILL);
    if (state_r == S_REFILL) begin
      mem_addr = {base_hi_r, cnt_r};
    end else begin
      mem_addr = '0;
    end
  end

  // Next-state logic of the refill FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (miss_s) begin
          state_nxt_s = S_REFILL;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REFILL: begin
        if (flush || (mem_ack && last_s)) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_REFILL;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM state, refill context, valid and LRU bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      base_hi_r  <= '0;
      idx_r      <= '0;
      fill_tag_r <= '0;
      way_r      <= 1'b0;
      lru_r      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_r[s] <= 2'b00;
      end
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        S_IDLE: begin
          if (flush) begin
            lru_r <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
              valid_r[s] <= 2'b00;
            end
          end else if (hit_s) begin
            lru_r[pc_idx_s] <= ~hit_way_s;
          end else if (miss_s) begin
            base_hi_r  <= pc[WORD_SIZE-1:BO_W];
            idx_r      <= pc_idx_s;
            fill_tag_r <= pc_tag_s;
            way_r      <= victim_s;
            cnt_r      <= '0;
          end
        end
        S_REFILL: begin
          // An aborted fill must never leave a half-written line visible.
          if (flush) begin
            valid_r[idx_r][way_r] <= 1'b0;
          end else if (mem_ack) begin
            cnt_r <= cnt_r + BO_W'(1);
            if (last_s) begin
              valid_r[idx_r][way_r] <= 1'b1;
              lru_r[idx_r]          <= ~way_r;
            end
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Line data and tag storage; contents are only meaningful under a set valid bit.
  always_ff @(posedge clk) begin
    if (fill_wr_s) begin
      data_r[way_r][idx_r][cnt_r] <= mem_data;
      if (last_s) begin
        tag_r[way_r][idx_r] <= fill_tag_r;
      end
    end
  end

`ifdef I_CACHE_ASSOC_STATS_EN
  logic [15:0] hit_count_r;
  logic [15:0] miss_count_r;

  // Saturating hit/miss statistics; flush leaves them untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_r  <= 16'h0000;
      miss_count_r <= 16'h0000;
    end else begin
      if (hit_s && (hit_count_r != 16'hFFFF)) begin
        hit_count_r <= hit_count_r + 16'h0001;
      end
      if (miss_s && (miss_count_r != 16'hFFFF)) begin
        miss_count_r <= miss_count_r + 16'h0001;
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_i_cache_assoc.sv
// Randomised self-checking bench for i_cache_assoc against a transaction-level cache model.
module tb_i_cache_assoc;

  localparam int WS  = 16;
  localparam int NS  = 2;
  localparam int LW  = 4;
  localparam int BOW = 2;
  localparam int IXW = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [WS-1:0] pc;
  logic          pc_valid;
  logic          flush;
  logic [WS-1:0] inst;
  logic          inst_valid;
  logic          mem_req;
  logic [WS-1:0] mem_addr;
  logic [WS-1:0] mem_data;
  logic          mem_ack;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;

  int n_checks = 0;
  int n_pass   = 0;

  bit m_valid [2][NS];
  int m_tag   [2][NS];
  bit m_lru   [NS];
  int m_hits;
  int m_misses;

  i_cache_assoc #(.WORD_SIZE(WS), .NUM_SETS(NS), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .inst(inst), .inst_valid(inst_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] memf(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  function automatic logic [31:0] exp_stat(input int n);
`ifdef I_CACHE_ASSOC_STATS_EN
    return (n > 65535) ? 32'd65535 : 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  function automatic int m_lookup(input int idx, input int tg);
    for (int w = 0; w < 2; w++) begin
      if (m_valid[w][idx] && m_tag[w][idx] == tg) return w;
    end
    return -1;
  endfunction

  function automatic int m_victim(input int idx);
    if (!m_valid[0][idx]) return 0;
    if (!m_valid[1][idx]) return 1;
    return int'(m_lru[idx]);
  endfunction

  task automatic m_clear(input bit counters);
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < NS; s++) m_valid[w][s] = 1'b0;
    end
    for (int s = 0; s < NS; s++) m_lru[s] = 1'b0;
    if (counters) begin
      m_hits   = 0;
      m_misses = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_hits"}, 32'(hit_count), exp_stat(m_hits));
    check_eq({tag, "_misses"}, 32'(miss_count), exp_stat(m_misses));
  endtask

  // One fetch of address a. abort_k >= 0 aborts the refill at word abort_k (flush, or reset if abort_rst).
  task automatic fetch(input logic [15:0] a, input int stall_k, input int stall_n,
                       input int abort_k, input bit abort_rst, input bit rnd_ack);
    int idx, tg, w, v, k, cyc, stalls;
    logic [15:0] base;
    bit ack;
    idx = int'(a[BOW +: IXW]);
    tg  = int'(a >> (BOW + IXW));
    pc = a; pc_valid = 1'b1; flush = 1'b0;
    mem_ack = 1'($urandom); mem_data = 16'($urandom);
    #1;
    w = m_lookup(idx, tg);
    if (w >= 0) begin
      check_eq("hit_valid", 32'(inst_valid), 32'd1);
      check_eq("hit_inst", 32'(inst), 32'(memf(a)));
      check_eq("hit_noreq", 32'(mem_req), 32'd0);
      m_lru[idx] = (w == 0);
      m_hits++;
      step();
      return;
    end
    check_eq("miss_valid", 32'(inst_valid), 32'd0);
    check_eq("miss_inst", 32'(inst), 32'd0);
    check_eq("miss_noreq", 32'(mem_req), 32'd0);
    v = m_victim(idx);
    m_misses++;
    base = a & 16'hFFFC;
    step();
    k = 0; cyc = 0; stalls = 0;
    while (k < LW && cyc < 64) begin
      pc = 16'($urandom); pc_valid = 1'($urandom);
      if (k == abort_k) begin
        mem_ack = 1'($urandom); mem_data = 16'($urandom);
        if (abort_rst) begin
          reset = 1'b1; mem_ack = 1'b0;
          #1;
          check_eq("rst_req", 32'(mem_req), 32'd0);
          check_eq("rst_addr", 32'(mem_addr), 32'd0);
          check_eq("rst_ivalid", 32'(inst_valid), 32'd0);
          check_eq("rst_inst", 32'(inst), 32'd0);
          m_clear(1'b1);
          check_stats("rst");
          step();
          reset = 1'b0;
          return;
        end
        flush = 1'b1;
        #1;
        check_eq("abort_addr_pre", 32'(mem_addr), 32'(base + 16'(k)));
        step();
        flush = 1'b0; mem_ack = 1'b0; pc_valid = 1'b0;
        #1;
        check_eq("abort_req", 32'(mem_req), 32'd0);
        check_eq("abort_addr", 32'(mem_addr), 32'd0);
        m_valid[v][idx] = 1'b0;
        return;
      end
      if (k == stall_k && stalls < stall_n) begin
        ack = 1'b0; stalls++;
      end else if (rnd_ack) begin
        ack = ($urandom % 3) != 0;
      end else begin
        ack = 1'b1;
      end
      mem_ack  = ack;
      mem_data = ack ? memf(base + 16'(k)) : 16'($urandom);
      #1;
      check_eq("fill_req", 32'(mem_req), 32'd1);
      check_eq("fill_addr", 32'(mem_addr), 32'(base + 16'(k)));
      check_eq("fill_ivalid", 32'(inst_valid), 32'd0);
      if (ack) k++;
      cyc++;
      step();
    end
    m_valid[v][idx] = 1'b1;
    m_tag[v][idx]   = tg;
    pc = a; pc_valid = 1'b1; mem_ack = 1'b0;
    #1;
    check_eq("post_fill_valid", 32'(inst_valid), 32'd1);
    check_eq("post_fill_inst", 32'(inst), 32'(memf(a)));
    check_eq("post_fill_req", 32'(mem_req), 32'd0);
    m_lru[idx] = (v == 0);
    m_hits++;
    step();
  endtask

  task automatic flush_idle(input logic [15:0] a);
    pc = a; pc_valid = 1'b1; flush = 1'b1; mem_ack = 1'b0;
    #1;
    check_eq("flush_ivalid", 32'(inst_valid), 32'd0);
    check_eq("flush_inst", 32'(inst), 32'd0);
    m_clear(1'b0);
    step();
    flush = 1'b0;
  endtask

  function automatic logic [15:0] rnd_addr();
    int t;
    t = $urandom_range(0, 5);
    if (t == 5) t = 13'h1FFF;
    return 16'((t << (BOW + IXW)) | ($urandom & 7));
  endfunction

  initial begin
    reset = 1'b1; pc = '0; pc_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_data = '0;
    m_clear(1'b1);
    step();
    check_eq("reset_ivalid", 32'(inst_valid), 32'd0);
    check_eq("reset_req", 32'(mem_req), 32'd0);
    check_eq("reset_addr", 32'(mem_addr), 32'd0);
    check_stats("reset");
    reset = 1'b0;
    step();

    fetch(16'h0005, -1, 0, -1, 1'b0, 1'b0);
    fetch(16'h0004, -1, 0, -1, 1'b0, 1'b0);
    fetch(16'h0006, -1, 0, -1, 1'b0, 1'b0);
    fetch(16'h0007, -1, 0, -1, 1'b0, 1'b0);
    check_stats("line5");

    fetch(16'h0000, -1, 0, -1, 1'b0, 1'b0);
    fetch(16'h0008, -1, 0, -1, 1'b0, 1'b0);
    fetch(16'h0000, -1, 0, -1, 1'b0, 1'b0);
    fetch(16'h0010, -1, 0, -1, 1'b0, 1'b0);
    fetch(16'h0000, -1, 0, -1, 1'b0, 1'b0);
    fetch(16'h0008, -1, 0, -1, 1'b0, 1'b0);

    fetch(16'h0024, 1, 3, -1, 1'b0, 1'b0);
    fetch(16'h0032, -1, 0, 2, 1'b0, 1'b0);
    fetch(16'h0032, -1, 0, -1, 1'b0, 1'b0);

    fetch(16'h0005, -1, 0, -1, 1'b0, 1'b0);
    flush_idle(16'h0005);
    fetch(16'h0005, -1, 0, -1, 1'b0, 1'b0);
    check_stats("directed");

    fetch(16'h0044, -1, 0, 1, 1'b1, 1'b0);
    fetch(16'h0005, -1, 0, -1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom % 20)
        0:       flush_idle(rnd_addr());
        1:       fetch(rnd_addr(), -1, 0, int'($urandom % LW), 1'b0, 1'b1);
        default: fetch(rnd_addr(), -1, 0, -1, 1'b0, 1'b1);
      endcase
    end
    check_stats("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
